sd_bd_fetch: RTL and testbench
==============================

# sd_bd_fetch

Consumer side of the SD controller buffer-descriptor (BD) queue. Detects pending descriptors from the queue's free-slot count and pops one descriptor word-by-word over the `re_s`/ack read port. It assembles the 32-bit system-buffer address and 32-bit SD block address, launches one block transfer on the data engine, and on completion returns the slot with the `a_cmp` release handshake. It sits between the BD queue and the SD data/command sequencer.

## Interface
- `DATA_W`, 32: BD queue word width (`RAM_MEM_WIDTH`); legal values 32 or 16.
- `BD_W`, `BD_WIDTH`: width of the free-slot count.
- `BD_CNT`, `BD_SIZE*DATA_W/64`: total descriptor slots. Equals `BD_SIZE/2` at 32 bit and `BD_SIZE/4` at 16 bit.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: fetch enable.
- `free_bd` in `BD_W`: free descriptor slots reported by the queue.
- `re_s` out 1: single-cycle pop request for one BD word.
- `ack_i_s` in 1: word valid, one cycle after `re_s`.
- `dat_in_s` in `DATA_W`: popped BD word.
- `a_cmp` out 1: slot release handshake.
- `xfer_start` out 1: one-cycle transfer launch.
- `xfer_sys_adr` out 32: system buffer address.
- `xfer_blk_adr` out 32: SD card block address.
- `xfer_done` in 1: one-cycle transfer completion.
- `xfer_err` in 1: error qualifier, sampled with `xfer_done`.
- `busy` out 1: high in every state except IDLE.
- `err_flag` out 1: sticky transfer error.
- `err_clr` in 1: clears `err_flag`.
- `bd_done_cnt` out 16: completed descriptors, wraps from 0xFFFF to 0.

## Operation
- Words per descriptor: `WPD = 64/DATA_W`, so 2 at 32 bit and 4 at 16 bit.
- Word order is fixed.
  - 32 bit: word0 = `sys_adr`, word1 = `blk_adr`.
  - 16 bit: `sys_adr[15:0]`, `sys_adr[31:16]`, `blk_adr[15:0]`, `blk_adr[31:16]`.
- Pending condition: `free_bd < BD_CNT`.
- States and transitions:
  - IDLE: if `en` and pending, go to REQ with word counter `wc=0`.
  - REQ: `re_s=1` for exactly this one cycle, then go to WACK.
  - WACK: wait for `ack_i_s`.
    - On ack, store `dat_in_s` into slice `wc`.
    - If `wc==WPD-1`, go to START; otherwise `wc++` and go to REQ.
  - START: `xfer_start=1` for one cycle, addresses valid, then go to RUN.
  - RUN: wait for `xfer_done`.
    - If `xfer_err` is also high, set `err_flag`.
    - Increment `bd_done_cnt` and go to REL1.
  - REL1, REL2: `a_cmp=1` in both cycles. A 2-cycle assertion guarantees the queue counts the release even if it collides with a queue write completing. Then go to GAP.
  - GAP: `a_cmp=0` for one cycle so the queue's `free_bd` settles. Then go to IDLE.
- Deasserting `en` takes effect only in IDLE. A descriptor whose first word has been popped is always completed and released, because the queue read pointer cannot be rewound.
- `err_clr` and a new error in the same cycle: the set wins.
- `xfer_sys_adr`/`xfer_blk_adr` hold their values from START until the next descriptor's word writes; they are not cleared after completion.
- `xfer_done` is ignored outside RUN.
- An `ack_i_s` arriving outside WACK is ignored.

## Timing
- Reset values: state IDLE, `re_s=0`, `a_cmp=0`, `xfer_start=0`, addresses 0, `busy=0`, `err_flag=0`, `bd_done_cnt=0`, `wc=0`.
- All outputs are registered (Moore-style).
- Pending seen in cycle 0:
  - `re_s` in cycles 1, 3, …, 2·WPD−1.
  - `xfer_start` in cycle 2·WPD+1, i.e. cycle 5 at 32 bit and cycle 9 at 16 bit.
- Only one read is outstanding at a time; `re_s` is never high in two consecutive cycles.
- `xfer_done` seen in cycle D:
  - `a_cmp` high in cycles D+1 and D+2, low in D+3.
  - Earliest next `re_s` in cycle D+5.
- Reset mid-operation returns to IDLE immediately. Partially assembled words are discarded, and `a_cmp` drops asynchronously.

## Structure
- `DATA_W` selection, `BD_WIDTH`, and `BD_SIZE` come from `sd_defines.v`.
- State encodings are local `localparam`s.
- No sub-module; the word assembler is an indexed register write inside the FSM block.

## Test plan
- 32-bit, one BD: `free_bd` drops from 8 to 7 with words 0x1000_0000 and 0x0000_0040.
  - Required: `re_s` in cycles 1 and 3, `xfer_start` in cycle 5 with `sys_adr=0x1000_0000`, `blk_adr=0x40`.
  - `xfer_done` → `a_cmp` high exactly 2 cycles; `bd_done_cnt=1`.
- 16-bit, one BD: words 0x0000, 0x2000, 0x0080, 0x0000.
  - Required: `sys_adr=0x2000_0000`, `blk_adr=0x0000_0080`, `xfer_start` in cycle 9.
- Back-to-back: `free_bd=BD_CNT-3` → 3 launches in FIFO order with no overlap. Each release is followed by a GAP cycle, and `bd_done_cnt=3`.
- Error path: `xfer_done` and `xfer_err` together → `err_flag=1` and `a_cmp` still issued. `err_clr` together with a new error → `err_flag` stays 1.
- Enable and reset:
  - `en` drops in WACK → the descriptor still completes, then the block stays in IDLE with pending present.
  - `rst` pulsed in RUN → all outputs at reset values within the same cycle.
- Wrap: preload `bd_done_cnt=0xFFFF` via 65535 forced completions (or `force`), then one more BD → count reads 0x0000.

Source files
------------

// File: rtl/sd_bd_fetch_pkg.sv
// sd_bd_fetch_pkg
//   Shared types and constants for the buffer-descriptor fetch block.
//   bd_state_e      : fetch FSM state encoding
//   BD_BITS         : bits per descriptor (sys_adr + blk_adr)
//   ADR_W / CNT_W   : address and completion-counter widths
//   words_per_bd()  : queue words needed to carry one descriptor
package sd_bd_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WACK,
        ST_START,
        ST_RUN,
        ST_REL1,
        ST_REL2,
        ST_GAP
    } bd_state_e;

    localparam int BD_BITS = 64;
    localparam int ADR_W   = 32;
    localparam int CNT_W   = 16;

    function automatic int words_per_bd(input int data_w);
        return BD_BITS / data_w;
    endfunction

endpackage

// File: rtl/sd_bd_fetch.sv
// sd_bd_fetch
//   Consumer side of the SD buffer-descriptor queue. Pops one descriptor a
//   word at a time, assembles the system buffer address and SD block
//   address, launches one block transfer and returns the slot afterwards.
//
// Ports
//   clk, rst        : system clock, asynchronous active-high reset
//   en              : fetch enable, only sampled while idle
//   free_bd         : free slot count from the queue (pending when < BD_CNT)
//   re_s            : one-cycle pop request for one queue word
//   ack_i_s/dat_in_s: popped word, valid one cycle after re_s
//   a_cmp           : slot release, high for two cycles
//   xfer_start      : one-cycle transfer launch
//   xfer_sys_adr    : system buffer address
//   xfer_blk_adr    : SD card block address
//   xfer_done/err   : transfer completion and its error qualifier
//   busy            : FSM not idle
//   err_flag/err_clr: sticky transfer error and its clear (set wins)
//   bd_done_cnt     : completed descriptors, free-running wrap
//
// state    | meaning
// ST_IDLE  | waiting for en and a pending descriptor
// ST_REQ   | re_s high, one word requested
// ST_WACK  | waiting for ack_i_s, word stored into slice wc
// ST_START | xfer_start high, addresses valid
// ST_RUN   | waiting for xfer_done
// ST_REL1  | a_cmp high, first cycle
// ST_REL2  | a_cmp high, second cycle
// ST_GAP   | a_cmp low so the queue's free count settles
module sd_bd_fetch
    import sd_bd_fetch_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int BD_SIZE = 16,
    parameter int BD_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BD_W-1:0]   free_bd,
    output logic              re_s,
    input  logic              ack_i_s,
    input  logic [DATA_W-1:0] dat_in_s,
    output logic              a_cmp,
    output logic              xfer_start,
    output logic [ADR_W-1:0]  xfer_sys_adr,
    output logic [ADR_W-1:0]  xfer_blk_adr,
    input  logic              xfer_done,
    input  logic              xfer_err,
    output logic              busy,
    output logic              err_flag,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  bd_done_cnt
);

    localparam int              WPD    = words_per_bd(DATA_W);
    localparam logic [BD_W-1:0] BD_CNT = BD_W'(BD_SIZE * DATA_W / BD_BITS);

    bd_state_e          state_q, state_d;
    logic [1:0]         wc_q, wc_d;
    logic [BD_BITS-1:0] bd_q, bd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               re_q, a_cmp_q, start_q, busy_q;
    logic               pending;

    assign pending = (free_bd < BD_CNT);

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        bd_d    = bd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        // Clear first so a simultaneous new error below overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en && pending) begin
                    state_d = ST_REQ;
                    wc_d    = 2'd0;
                end
            end
            ST_REQ: begin
                state_d = ST_WACK;
            end
            ST_WACK: begin
                if (ack_i_s) begin
                    // Word wc lands in bits [wc*DATA_W +: DATA_W]; sys_adr is
                    // the low half of the descriptor, blk_adr the high half.
                    for (int i = 0; i < WPD; i++) begin
                        if (wc_q == 2'(i)) begin
                            bd_d[i*DATA_W +: DATA_W] = dat_in_s;
                        end
                    end
                    if (wc_q == 2'(WPD - 1)) begin
                        state_d = ST_START;
                    end else begin
                        wc_d    = wc_q + 2'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (xfer_done) begin
                    if (xfer_err) begin
                        err_d = 1'b1;
                    end
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_REL1;
                end
            end
            ST_REL1: state_d = ST_REL2;
            ST_REL2: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe without any combinational decode on the ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wc_q    <= 2'd0;
            bd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            re_q    <= 1'b0;
            a_cmp_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            bd_q    <= bd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            re_q    <= (state_d == ST_REQ);
            a_cmp_q <= (state_d == ST_REL1) || (state_d == ST_REL2);
            start_q <= (state_d == ST_START);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign re_s         = re_q;
    assign a_cmp        = a_cmp_q;
    assign xfer_start   = start_q;
    assign busy         = busy_q;
    assign err_flag     = err_q;
    assign bd_done_cnt  = cnt_q;
    assign xfer_sys_adr = bd_q[ADR_W-1:0];
    assign xfer_blk_adr = bd_q[BD_BITS-1:ADR_W];

endmodule

// File: tb/tb_sd_bd_fetch.sv
// tb_sd_bd_fetch
//   Drives a 32-bit and a 16-bit sd_bd_fetch. The 32-bit instance is served
//   by a behavioural descriptor queue (list of pending descriptors plus an
//   unreleased-slot count) and a data-engine model; the 16-bit instance is
//   exercised with a short directed sequence.
module tb_sd_bd_fetch;

    localparam int BD_SIZE = 16;
    localparam int BD_W    = 8;
    localparam int CNT32   = BD_SIZE * 32 / 64;
    localparam int CNT16   = BD_SIZE * 16 / 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-bit instance
    logic            en, re_s, ack_i_s, a_cmp, xfer_start, xfer_done, xfer_err;
    logic            busy, err_flag, err_clr;
    logic [31:0]     dat_in_s, sys_adr, blk_adr;
    logic [BD_W-1:0] free_bd;
    logic [15:0]     done_cnt;

    // 16-bit instance
    logic            en16, re16, ack16, acmp16, start16, done16, xerr16;
    logic            busy16, errf16, clr16;
    logic [15:0]     dat16;
    logic [31:0]     sys16, blk16;
    logic [BD_W-1:0] free16;
    logic [15:0]     cnt16;

    sd_bd_fetch #(.DATA_W(32), .BD_SIZE(BD_SIZE), .BD_W(BD_W)) dut32 (
        .clk(clk), .rst(rst), .en(en), .free_bd(free_bd), .re_s(re_s),
        .ack_i_s(ack_i_s), .dat_in_s(dat_in_s), .a_cmp(a_cmp),
        .xfer_start(xfer_start), .xfer_sys_adr(sys_adr), .xfer_blk_adr(blk_adr),
        .xfer_done(xfer_done), .xfer_err(xfer_err), .busy(busy),
        .err_flag(err_flag), .err_clr(err_clr), .bd_done_cnt(done_cnt)
    );

    sd_bd_fetch #(.DATA_W(16), .BD_SIZE(BD_SIZE), .BD_W(BD_W)) dut16 (
        .clk(clk), .rst(rst), .en(en16), .free_bd(free16), .re_s(re16),
        .ack_i_s(ack16), .dat_in_s(dat16), .a_cmp(acmp16),
        .xfer_start(start16), .xfer_sys_adr(sys16), .xfer_blk_adr(blk16),
        .xfer_done(done16), .xfer_err(xerr16), .busy(busy16),
        .err_flag(errf16), .err_clr(clr16), .bd_done_cnt(cnt16)
    );

    int vec = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue model: pend holds descriptors not fully popped, expq holds
    // descriptors not yet launched, unrel counts slots not yet released.
    logic [63:0] pend[$];
    logic [63:0] expq[$];
    int          reqc[$];
    int          startc[$];
    int          unrel     = 0;
    int          wptr      = 0;
    int          last_done = -1000;
    bit          stray_en  = 0;

    assign free_bd = BD_W'(CNT32 - unrel);

    task automatic push(input logic [63:0] d);
        pend.push_back(d);
        expq.push_back(d);
        unrel++;
    endtask

    // Queue read port
    initial begin
        bit ack_pend, acmp_prev, re_prev, outstanding;
        ack_pend = 0; acmp_prev = 0; re_prev = 0; outstanding = 0;
        forever begin
            @(posedge clk); #1;
            ack_i_s = 1'b0;
            if (rst) begin
                ack_pend = 0; acmp_prev = 0; re_prev = 0; outstanding = 0;
            end else begin
                if (ack_pend) begin
                    ack_i_s  = 1'b1;
                    ack_pend = 0;
                    if (pend.size() == 0) begin
                        chk("pop_from_empty_queue", 1, 0);
                        dat_in_s = '0;
                    end else begin
                        dat_in_s = 32'(pend[0] >> (32 * wptr));
                        wptr++;
                        if (wptr == 2) begin
                            void'(pend.pop_front());
                            wptr = 0;
                        end
                    end
                end else if (stray_en && $urandom_range(0, 3) == 0) begin
                    ack_i_s  = 1'b1;
                    dat_in_s = $urandom;
                end
                if (re_s) begin
                    chk("re_single_cycle", 64'(re_prev), 0);
                    chk("re_after_release_gap", 64'(cyc - last_done >= 5), 1);
                    reqc.push_back(cyc);
                    ack_pend = 1;
                end
                if (xfer_start) begin
                    chk("start_while_unreleased", 64'(outstanding), 0);
                    outstanding = 1;
                end
                if (a_cmp && !acmp_prev) begin
                    unrel--;
                    outstanding = 0;
                end
                re_prev   = re_s;
                acmp_prev = a_cmp;
            end
        end
    end

    // Data engine model
    int          err_mode  = 0;
    int          clr_mode  = 0;
    bit          hold_done = 0;
    bit          abort     = 0;
    bit          eng_busy  = 0;
    bit          err_exp   = 0;
    logic [15:0] cnt_exp   = '0;

    initial begin
        logic [63:0] d;
        int          dly;
        bit          e, c;
        forever begin
            @(posedge clk); #1;
            xfer_done = 1'b0;
            xfer_err  = 1'b0;
            if (xfer_start && !rst) begin
                eng_busy = 1;
                startc.push_back(cyc);
                if (expq.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    d = expq.pop_front();
                    chk("xfer_sys_adr", 64'(sys_adr), 64'(d[31:0]));
                    chk("xfer_blk_adr", 64'(blk_adr), 64'(d[63:32]));
                end
                dly = $urandom_range(0, 4);
                @(posedge clk); #1;
                chk("start_one_cycle", 64'(xfer_start), 0);
                repeat (dly) begin @(posedge clk); #1; end
                while (hold_done && !abort) begin @(posedge clk); #1; end
                if (abort) begin
                    abort    = 0;
                    eng_busy = 0;
                end else begin
                    e = (err_mode == 1) || (err_mode == 2 && $urandom_range(0, 2) == 0);
                    c = (clr_mode == 1) || (clr_mode == 2 && $urandom_range(0, 2) == 0);
                    xfer_done = 1'b1;
                    xfer_err  = e;
                    err_clr   = c;
                    cnt_exp++;
                    err_exp   = e ? 1'b1 : (c ? 1'b0 : err_exp);
                    last_done = cyc;
                    @(posedge clk); #1;
                    xfer_done = 1'b0;
                    xfer_err  = 1'b0;
                    err_clr   = 1'b0;
                    chk("a_cmp_rel1", 64'(a_cmp), 1);
                    chk("bd_done_cnt", 64'(done_cnt), 64'(cnt_exp));
                    chk("err_flag", 64'(err_flag), 64'(err_exp));
                    @(posedge clk); #1;
                    chk("a_cmp_rel2", 64'(a_cmp), 1);
                    @(posedge clk); #1;
                    chk("a_cmp_gap", 64'(a_cmp), 0);
                    chk("busy_gap", 64'(busy), 1);
                    eng_busy = 0;
                end
            end else if (stray_en && !rst && $urandom_range(0, 5) == 0) begin
                xfer_done = 1'b1;
                xfer_err  = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((unrel != 0 || eng_busy || busy) && n < budget);
        if (n >= budget) chk({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, n, nb, rj, w;
        bit          ack_next, got;
        logic [15:0] c0;
        logic [63:0] d16[2];

        en = 0; ack_i_s = 0; dat_in_s = '0; xfer_done = 0; xfer_err = 0; err_clr = 0;
        en16 = 0; ack16 = 0; dat16 = '0; done16 = 0; xerr16 = 0; clr16 = 0;
        free16 = BD_W'(CNT16);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_re_s", 64'(re_s), 0);
        chk("rst_a_cmp", 64'(a_cmp), 0);
        chk("rst_xfer_start", 64'(xfer_start), 0);
        chk("rst_sys_adr", 64'(sys_adr), 0);
        chk("rst_blk_adr", 64'(blk_adr), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err_flag", 64'(err_flag), 0);
        chk("rst_done_cnt", 64'(done_cnt), 0);
        chk("rst16_busy", 64'(busy16), 0);
        chk("rst16_re", 64'(re16), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b1;
        en16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // One descriptor, cycle-exact
        reqc.delete(); startc.delete();
        t0 = cyc;
        push(64'h0000_0040_1000_0000);
        wait_idle(100, "single");
        chk("single_re_count", 64'(reqc.size()), 2);
        if (reqc.size() == 2) begin
            chk("single_re0_cycle", 64'(reqc[0] - t0), 1);
            chk("single_re1_cycle", 64'(reqc[1] - t0), 3);
        end
        chk("single_start_count", 64'(startc.size()), 1);
        if (startc.size() == 1) chk("single_start_cycle", 64'(startc[0] - t0), 5);
        chk("single_done_cnt", 64'(done_cnt), 1);
        chk("addr_hold_sys", 64'(sys_adr), 64'h1000_0000);

        // Back-to-back three descriptors
        startc.delete();
        repeat (3) push({$urandom, $urandom});
        wait_idle(300, "b2b");
        chk("b2b_launches", 64'(startc.size()), 3);
        chk("b2b_done_cnt", 64'(done_cnt), 4);

        // Error path
        err_mode = 1;
        push({$urandom, $urandom});
        wait_idle(100, "err1");
        chk("err_set", 64'(err_flag), 1);
        clr_mode = 1;
        push({$urandom, $urandom});
        wait_idle(100, "err2");
        chk("err_set_beats_clr", 64'(err_flag), 1);
        err_mode = 0; clr_mode = 0;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        err_exp = 1'b0;
        chk("err_cleared", 64'(err_flag), 0);

        // Randomized traffic with stray acks and stray completions
        stray_en = 1; err_mode = 2; clr_mode = 2;
        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(1, CNT32);
            for (int k = 0; k < n; k++) push({$urandom, $urandom});
            wait_idle(600, "rand");
            chk("rand_done_cnt", 64'(done_cnt), 64'(cnt_exp));
            chk("rand_err_flag", 64'(err_flag), 64'(err_exp));
        end
        stray_en = 0; err_mode = 0; clr_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rand_final_err", 64'(err_flag), 64'(err_exp));

        // Enable dropped while waiting for the first word's ack
        c0 = done_cnt;
        push({$urandom, $urandom});
        push({$urandom, $urandom});
        n = 0;
        while (!re_s && n < 50) begin @(posedge clk); #1; n++; end
        chk("en_first_re_seen", 64'(re_s), 1);
        @(posedge clk); #1;
        en = 1'b0;
        repeat (30) @(posedge clk);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (busy) nb++;
        end
        chk("en_drop_one_completed", 64'(done_cnt - c0), 1);
        chk("en_drop_stays_idle", 64'(nb), 0);
        chk("en_drop_pending_left", 64'(expq.size()), 1);
        en = 1'b1;
        wait_idle(100, "en_resume");
        chk("en_resume_done", 64'(done_cnt - c0), 2);

        // Reset while a transfer is running
        hold_done = 1;
        push({$urandom, $urandom});
        n = 0;
        while (!eng_busy && n < 50) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("run_rst_busy", 64'(busy), 0);
        chk("run_rst_re", 64'(re_s), 0);
        chk("run_rst_a_cmp", 64'(a_cmp), 0);
        chk("run_rst_start", 64'(xfer_start), 0);
        chk("run_rst_sys", 64'(sys_adr), 0);
        chk("run_rst_blk", 64'(blk_adr), 0);
        chk("run_rst_err", 64'(err_flag), 0);
        chk("run_rst_cnt", 64'(done_cnt), 0);
        pend.delete(); expq.delete();
        unrel = 0; wptr = 0; cnt_exp = '0; err_exp = 0;
        abort = 1; hold_done = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(busy), 0);
        push({$urandom, $urandom});
        wait_idle(100, "post_rst");
        chk("post_rst_done_cnt", 64'(done_cnt), 1);

        // Completion counter wrap
        force dut32.cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut32.cnt_q;
        cnt_exp = 16'hFFFF;
        @(posedge clk); #1;
        chk("wrap_preload", 64'(done_cnt), 64'hFFFF);
        push({$urandom, $urandom});
        wait_idle(100, "wrap");
        chk("wrap_done_cnt", 64'(done_cnt), 0);

        // 16-bit instance: directed words, then a random descriptor
        d16[0] = 64'h0000_0080_2000_0000;
        d16[1] = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            free16 = BD_W'(CNT16 - 1);
            t0 = cyc; rj = 0; w = 0; ack_next = 0; got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(posedge clk); #1;
                ack16 = 1'b0;
                if (ack_next) begin
                    ack16 = 1'b1;
                    dat16 = 16'(d16[i] >> (16 * w));
                    w++;
                    ack_next = 0;
                end
                if (re16) begin
                    chk("w16_re_cycle", 64'(cyc - t0), 64'(2 * rj + 1));
                    rj++;
                    ack_next = 1;
                end
                if (start16) begin
                    got = 1;
                    chk("w16_start_cycle", 64'(cyc - t0), 9);
                    chk("w16_sys_adr", 64'(sys16), 64'(d16[i][31:0]));
                    chk("w16_blk_adr", 64'(blk16), 64'(d16[i][63:32]));
                end
            end
            if (!got) chk("w16_start_timeout", 1, 0);
            @(posedge clk); #1;
            done16 = 1'b1;
            @(posedge clk); #1;
            done16 = 1'b0;
            chk("w16_a_cmp_rel1", 64'(acmp16), 1);
            free16 = BD_W'(CNT16);
            @(posedge clk); #1;
            chk("w16_a_cmp_rel2", 64'(acmp16), 1);
            @(posedge clk); #1;
            chk("w16_a_cmp_gap", 64'(acmp16), 0);
            @(posedge clk); #1;
            chk("w16_idle", 64'(busy16), 0);
            chk("w16_done_cnt", 64'(cnt16), 64'(i + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
